// File: rtl/reg_bus_arbiter.sv
// Arbitrates N_REQ register-bus requesters onto one cmd/addr/data bus; optional macro REG_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: accept at t, bus command at t+1, write completion at t+2, read completion at t+2+RD_LAT.
// Backpressure: req_rdy only in IDLE, one-hot to the winner; losers hold their request until granted.
module reg_bus_arbiter #(
    parameter int N_REQ  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [2*N_REQ-1:0]    req_cmd,
    input  logic [8*N_REQ-1:0]    req_addr,
    input  logic [32*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            cmd,
    output logic [7:0]            cmd_addr,
    output logic [31:0]           cmd_data_m2s,
    input  logic [31:0]           cmd_data_s2m
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [2:0] RD_CNT_INIT = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_REQ-1:0]  eligible;
    logic              found;
    logic [IW-1:0]     winner;
    logic              accept;
    logic [1:0]        lat_cmd;
    logic [7:0]        lat_addr;
    logic [31:0]       lat_wdata;
    logic [IW-1:0]     lat_idx;
    logic [2:0]        rd_cnt;
    logic [N_REQ-1:0]  rsp_vld_q;
    logic [31:0]       rsp_rdata_q;

    // Only WRITE and READ are grantable; 00/11 never reach the bus.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_vld[i] &&
                          (req_cmd[2*i +: 2] == CMD_WRITE || req_cmd[2*i +: 2] == CMD_READ);
        end
    end

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] last_grant;
    int            rr_idx;

    // Scan offsets from farthest to nearest so the nearest eligible index after last_grant wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            rr_idx = int'(last_grant) + k;
            if (rr_idx >= N_REQ) begin
                rr_idx = rr_idx - N_REQ;
            end
            if (eligible[rr_idx]) begin
                found  = 1'b1;
                winner = IW'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant <= IW'(N_REQ - 1);
        end else if (accept) begin
            last_grant <= winner;
        end
    end
`endif

    assign accept = rstn && (state == ST_IDLE) && found;

    always_comb begin
        req_rdy = '0;
        if (accept) begin
            req_rdy[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = (lat_cmd == CMD_READ) ? ST_RD_WAIT : ST_IDLE;
            ST_RD_WAIT: if (rd_cnt == 3'd0) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lat_cmd     <= CMD_IDLE;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_idx     <= '0;
            rd_cnt      <= '0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_vld_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_cmd   <= req_cmd[int'(winner)*2 +: 2];
                        lat_addr  <= req_addr[int'(winner)*8 +: 8];
                        lat_wdata <= req_wdata[int'(winner)*32 +: 32];
                        lat_idx   <= winner;
                    end
                end
                ST_ISSUE: begin
                    if (lat_cmd == CMD_READ) begin
                        rd_cnt <= RD_CNT_INIT;
                    end else begin
                        rsp_vld_q[lat_idx] <= 1'b1;
                        rsp_rdata_q        <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_cnt == 3'd0) begin
                        rsp_vld_q[lat_idx] <= 1'b1;
                        rsp_rdata_q        <= cmd_data_s2m;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The bus is driven only during ISSUE; read commands never carry write data.
    assign cmd          = (state == ST_ISSUE) ? lat_cmd : CMD_IDLE;
    assign cmd_addr     = (state == ST_ISSUE) ? lat_addr : 8'h00;
    assign cmd_data_m2s = (state == ST_ISSUE && lat_cmd == CMD_WRITE) ? lat_wdata : 32'h0;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_rdata    = rsp_rdata_q;

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Arbitrates N register-bus requesters (sequences, firmware model, scoreboard back-door) onto the single MCDF register command bus (cmd / cmd_addr / cmd_data_m2s / cmd_data_s2m). It accepts one command at a time through a valid/ready handshake and drives it onto the bus for exactly one cycle. For a read it waits a fixed slave latency and returns the captured data to the winning requester. It sits between the requester ports and the register slave, and owns the bus exclusively.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- RD_LAT, 1: cycles from the READ command cycle until cmd_data_s2m is valid, 1..7.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- req_vld  in  N_REQ  per-requester command valid.
- req_cmd  in  2*N_REQ  packed; 2'b01 WRITE, 2'b10 READ.
- req_addr  in  8*N_REQ  packed register address.
- req_wdata  in  32*N_REQ  packed write data.
- req_rdy  out  N_REQ  one-hot accept, combinational.
- rsp_vld  out  N_REQ  one-hot completion pulse, registered.
- rsp_rdata  out  32  read data, valid with rsp_vld.
- cmd  out  2  bus command: 00 IDLE, 01 WRITE, 10 READ.
- cmd_addr  out  8  bus address.
- cmd_data_m2s  out  32  bus write data.
- cmd_data_s2m  in  32  bus read data from the slave.

## Operation
- FSM states:
  - IDLE: if any eligible request exists, assert req_rdy[w] for the winner w. An accepted request (req_vld & req_rdy) is latched into cmd/addr/data registers. Next state is ISSUE.
  - ISSUE: cmd, cmd_addr and cmd_data_m2s carry the latched command for exactly this cycle. WRITE goes to IDLE. READ loads the counter with RD_LAT-1 and goes to RD_WAIT.
  - RD_WAIT: decrement the counter. At 0, capture cmd_data_s2m into rsp_rdata and go to IDLE.
- Eligible request: req_vld[i]=1 and req_cmd[i] is 01 or 10. Requests with cmd 00 or 11 are never granted; req_rdy stays 0 for them.
- req_rdy is 0 in every state except IDLE. Requesters hold all request fields stable while req_vld=1 and req_rdy=0.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps from N_REQ-1 to 0. last_grant updates only on accept. Reset value of last_grant is N_REQ-1, so requester 0 wins first.
- Completion: rsp_vld[w] pulses for one cycle, in the cycle the FSM re-enters IDLE.
  - WRITE: rsp_rdata = 0.
  - READ: rsp_rdata = captured data.
  - rsp_rdata holds its value until the next completion.
- When not in ISSUE: cmd=00, cmd_addr=0, cmd_data_m2s=0. During a READ ISSUE, cmd_data_m2s=0.
- Reset mid-operation: the FSM returns to IDLE and any outstanding read is abandoned. No rsp_vld is generated for it.

## Timing
- Reset values: cmd=0, cmd_addr=0, cmd_data_m2s=0, req_rdy=0, rsp_vld=0, rsp_rdata=0, state=IDLE.
- Accept at cycle t; bus command at t+1.
- WRITE: rsp_vld at t+2.
- READ: data sampled on cmd_data_s2m at t+1+RD_LAT; rsp_vld and rsp_rdata at t+2+RD_LAT.
- A new accept is allowed in the same cycle as rsp_vld (IDLE).
- Throughput: back-to-back writes put a bus command every 2 cycles. Back-to-back reads put one every RD_LAT+2 cycles.
- Simultaneous requests: exactly one grant per accept. Losers keep req_vld asserted.

## Configuration
- REG_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest eligible index always wins and last_grant is unused.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single write: reset, then req0 WRITE addr 0x14, data 0xDEADBEEF → req_rdy[0] at t; cmd=01/0x14/0xDEADBEEF at t+1 only; rsp_vld[0] at t+2 with rsp_rdata=0.
- Single read, RD_LAT=2: req2 READ addr 0x08, slave drives 0x0000_00A5 at t+3 → rsp_vld[2] at t+4 with rsp_rdata=0xA5. cmd=10 at t+1 only.
- Round-robin fairness: all 4 requesters hold WRITE continuously → grant order 0,1,2,3,0,1 with accepts every 2 cycles. With REG_ARB_FIXED_PRIO_EN defined → 0,0,0,….
- Illegal command: req1 req_cmd=11 while req3 issues a READ → req1 is never granted, req3 completes normally, and cmd never equals 11.
- Reset mid-read: assert rstn=0 in RD_WAIT → the next cycle shows all outputs at reset values, no rsp_vld, and requester 0 is granted first after release.
- Accept on completion cycle: req0 READ in flight while req1 WRITE is pending → req_rdy[1] is asserted in the same cycle as rsp_vld[0], and req1's cmd appears on the bus the following cycle.
